// File: rtl/alu_ex_stage_pkg.sv
// Shared definitions for the ALU execute stage: widths, ALU opcodes and the
// registered result payload carried toward writeback.
package alu_ex_stage_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned RD_W      = 5;
   localparam int unsigned OVF_CNT_W = 16;
   localparam int unsigned CTRL_W    = 4;
   localparam int unsigned SHAMT_W   = 5;

   typedef enum logic [CTRL_W-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd4,
      ALU_OR  = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_SLT = 4'd8
   } alu_ctrl_e;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic            overflow;
      logic            illegal;
      logic [RD_W-1:0] rd;
   } ex_entry_t;

   // True for the ctrl codes the ALU implements.
   function automatic logic ctrl_legal(input logic [CTRL_W-1:0] ctrl);
      case (ctrl)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
         ALU_SLL, ALU_SRL, ALU_SLT: return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_ex_stage_alu.sv
// Existing combinational ALU: two's-complement add/sub with signed overflow,
// bitwise logic, logical shifts and signed set-less-than.
module alu_ex_stage_alu
   import alu_ex_stage_pkg::*;
(
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [XLEN-1:0]   op1,
   input  logic [XLEN-1:0]   op2,
   output logic [XLEN-1:0]   result,
   output logic              overflow
);

   logic [XLEN-1:0]    sum;
   logic [XLEN-1:0]    diff;
   logic [SHAMT_W-1:0] shamt;
   logic               op1_neg;
   logic               op2_neg;

   assign sum     = op1 + op2;
   assign diff    = op1 - op2;
   assign shamt   = op2[SHAMT_W-1:0];
   assign op1_neg = op1[XLEN-1];
   assign op2_neg = op2[XLEN-1];

   // Unknown codes fall through to zero; the stage flags them separately.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            result   = sum;
            overflow = (op1_neg == op2_neg) && (sum[XLEN-1] != op1_neg);
         end
         ALU_SUB: begin
            result   = diff;
            overflow = (op1_neg != op2_neg) && (diff[XLEN-1] != op1_neg);
         end
         ALU_AND: result = op1 & op2;
         ALU_OR:  result = op1 | op2;
         ALU_SLL: result = op1 << shamt;
         ALU_SRL: result = op1 >> shamt;
         ALU_SLT: result = XLEN'($signed(op1) < $signed(op2));
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage in front of the ALU: valid/ready intake, main + skid output
// buffer toward writeback, illegal-ctrl flagging and a saturating overflow count.
module alu_ex_stage
   import alu_ex_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CTRL_W-1:0]    in_ctrl,
   input  logic [XLEN-1:0]      in_op1,
   input  logic [XLEN-1:0]      in_op2,
   input  logic [RD_W-1:0]      in_rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_result,
   output logic                 out_overflow,
   output logic                 out_illegal,
   output logic [RD_W-1:0]      out_rd,
   output logic [OVF_CNT_W-1:0] ovf_count
);

   logic [XLEN-1:0]      alu_result;
   logic                 alu_overflow;
   logic                 legal;
   ex_entry_t            new_entry;
   ex_entry_t            main_q;
   ex_entry_t            skid_q;
   logic                 main_valid;
   logic                 skid_valid;
   logic                 accept;
   logic                 transfer;
   logic [OVF_CNT_W-1:0] ovf_count_q;

   alu_ex_stage_alu u_alu (
      .ctrl     (in_ctrl),
      .op1      (in_op1),
      .op2      (in_op2),
      .result   (alu_result),
      .overflow (alu_overflow)
   );

   assign legal = ctrl_legal(in_ctrl);

   // Illegal ops still flow through the buffer, carrying a zero result.
   always_comb begin
      new_entry          = '0;
      new_entry.result   = legal ? alu_result : '0;
      new_entry.overflow = legal & alu_overflow;
      new_entry.illegal  = ~legal;
      new_entry.rd       = in_rd;
   end

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready;
   assign transfer = main_valid & out_ready;

   // Main always holds the oldest op; skid only fills while main is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid) begin
         if (accept) begin
            main_q     <= new_entry;
            main_valid <= 1'b1;
         end
      end else if (transfer) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= new_entry;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= new_entry;
         skid_valid <= 1'b1;
      end
   end

   // Counts overflowing ops at intake and sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_count_q <= '0;
      end else if (accept && new_entry.overflow && (ovf_count_q != '1)) begin
         ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
      end
   end

   assign out_valid    = main_valid;
   assign out_result   = main_q.result;
   assign out_overflow = main_q.overflow;
   assign out_illegal  = main_q.illegal;
   assign out_rd       = main_q.rd;
   assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed cases plus randomized traffic
// checked against a queue-based behavioural model.
module tb_alu_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_ctrl;
   logic [31:0] in_op1;
   logic [31:0] in_op2;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_illegal;
   logic [4:0]  out_rd;
   logic [15:0] ovf_count;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        ill;
      logic [4:0]  rd;
   } exp_t;

   exp_t        q[$];
   logic [4:0]  seen_rd[$];
   int          mcnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   alu_ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ctrl      (in_ctrl),
      .in_op1       (in_op1),
      .in_op2       (in_op2),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_illegal  (out_illegal),
      .out_rd       (out_rd),
      .ovf_count    (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference ALU using wide signed arithmetic rather than sign-bit rules.
   function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd);
      exp_t   e;
      longint s;
      e.res = 32'd0; e.ovf = 1'b0; e.ill = 1'b0; e.rd = rd;
      case (c)
         4'd0: begin
            s = longint'($signed(a)) + longint'($signed(b));
            e.res = s[31:0];
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            s = longint'($signed(a)) - longint'($signed(b));
            e.res = s[31:0];
            e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd4: e.res = a & b;
         4'd5: e.res = a | b;
         4'd6: e.res = a << b[4:0];
         4'd7: e.res = a >> b[4:0];
         4'd8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Monitor: handshakes are decided by values stable at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         mcnt = 0;
      end else begin
         chk("ovf_count", 64'(ovf_count), 64'(mcnt));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_result", 64'(out_result), 64'(e.res));
            chk("out_overflow", 64'(out_overflow), 64'(e.ovf));
            chk("out_illegal", 64'(out_illegal), 64'(e.ill));
            chk("out_rd", 64'(out_rd), 64'(e.rd));
            seen_rd.push_back(out_rd);
         end
         if (in_valid && in_ready) begin
            e = ref_alu(in_ctrl, in_op1, in_op2, in_rd);
            q.push_back(e);
            if (e.ovf && mcnt < 65535) mcnt++;
         end
      end
   end

   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
      bit acc = 1'b0;
      int n = 0;
      in_valid = 1'b1; in_ctrl = c; in_op1 = a; in_op2 = b; in_rd = rd;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom % 5)
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'(int'($urandom % 64) - 32);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ctbl[9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd15};
      logic [31:0] t2_exp[5] = '{32'd231, 32'd2, 32'd235, 32'd1872, 32'd29};
      logic [3:0]  t2_ctl[5] = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
      logic [31:0] t3_a[4]   = '{32'd45, 32'd25, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      logic [31:0] t3_b[4]   = '{32'd42, 32'd42, 32'd42, 32'hFFFF_FFF0};
      logic [31:0] t3_exp[4] = '{32'd0, 32'd1, 32'd1, 32'd0};
      logic [15:0] cnt_before;
      bit          acc;
      int          n;

      rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_op1 = '0; in_op2 = '0; in_rd = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
      chk("rst_out_overflow", 64'(out_overflow), 64'd0);
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
      chk("rst_out_rd", 64'(out_rd), 64'd0);
      chk("rst_ovf_count", 64'(ovf_count), 64'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // ADD overflow
      send(4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd1);
      in_valid = 1'b0;
      chk("t1_result", 64'(out_result), 64'(32'hFFFF_FFFE));
      chk("t1_overflow", 64'(out_overflow), 64'd1);
      chk("t1_ovf_count", 64'(ovf_count), 64'd1);

      // Back-to-back ops on 234, 3
      for (int i = 0; i < 5; i++) begin
         send(t2_ctl[i], 32'd234, 32'd3, 5'(i + 2));
         chk("t2_result", 64'(out_result), 64'(t2_exp[i]));
         chk("t2_overflow", 64'(out_overflow), 64'd0);
         chk("t2_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;

      // SLT signed cases
      for (int i = 0; i < 4; i++) begin
         send(4'd8, t3_a[i], t3_b[i], 5'(i + 10));
         chk("t3_result", 64'(out_result), 64'(t3_exp[i]));
         chk("t3_rd", 64'(out_rd), 64'(i + 10));
      end
      in_valid = 1'b0;

      // Backpressure: two accepted, third stalls, all delivered in order
      repeat (3) @(posedge clk);
      #1;
      seen_rd.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 4'd0; in_op1 = 32'd1; in_op2 = 32'd2; in_rd = 5'd20;
      @(posedge clk); #1;
      in_rd = 5'd21; in_op1 = 32'd3;
      @(posedge clk); #1;
      chk("t4_in_ready_b", 64'(in_ready), 64'd0);
      in_rd = 5'd22; in_op1 = 32'd5;
      @(posedge clk); #1;
      chk("t4_in_ready_c", 64'(in_ready), 64'd0);
      chk("t4_hold_rd", 64'(out_rd), 64'd20);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 10) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk("t4_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_count", 64'(seen_rd.size()), 64'd3);
      for (int i = 0; i < 3 && i < seen_rd.size(); i++)
         chk("t4_order", 64'(seen_rd[i]), 64'(20 + i));

      // Illegal ctrl
      cnt_before = ovf_count;
      send(4'd2, 32'd5, 32'd6, 5'd7);
      in_valid = 1'b0;
      chk("t5_result", 64'(out_result), 64'd0);
      chk("t5_illegal", 64'(out_illegal), 64'd1);
      chk("t5_overflow", 64'(out_overflow), 64'd0);
      chk("t5_ovf_count", 64'(ovf_count), 64'(cnt_before));

      // Randomized traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_ctrl   = ctbl[$urandom % 9];
         in_op1    = rand_op();
         in_op2    = rand_op();
         in_rd     = 5'($urandom);
         out_ready = ($urandom % 3) != 0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Reset with main and skid both full
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 4'd0; in_op1 = 32'h7FFF_FFFF; in_op2 = 32'd1; in_rd = 5'd30;
      @(posedge clk); #1;
      in_rd = 5'd31;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t6_full_in_ready", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_ovf_count", 64'(ovf_count), 64'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_out_valid", 64'(out_valid), 64'd0);

      // Saturation of the overflow counter
      in_valid = 1'b1; in_ctrl = 4'd0; in_op1 = 32'h7FFF_FFFF; in_op2 = 32'd1; in_rd = 5'd3;
      repeat (65540) @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_sat", 64'(ovf_count), 64'h0000_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
